// File: rtl/dma_addr_page_latch_if.sv
// rtl/dma_addr_page_latch_if.sv - CPU page-register and DMA bus signal bundle
//
// Purpose: groups the CPU page-register port, the 8237A-side address and
// strobe inputs, and the system-address outputs of dma_addr_page_latch.
// Ports (all in the bundle):
//   page_cs/page_wr/page_rd/page_sel/page_din/page_dout  CPU page register access
//   AEN/ADSTB/DB_IN/A_LO/DACK/MEMR_N/MEMW_N              controller bus side
//   SYS_ADDR/ADDR_VALID/ACT_CH/BOUNDARY_ERR              system address side
// master drives the inputs of the latch; slave is the latch itself.
interface dma_addr_page_latch_if #(
  parameter int PAGE_W = 8
);
  logic                  page_cs;
  logic                  page_wr;
  logic                  page_rd;
  logic [1:0]            page_sel;
  logic [PAGE_W-1:0]     page_din;
  logic [PAGE_W-1:0]     page_dout;
  logic                  AEN;
  logic                  ADSTB;
  logic [7:0]            DB_IN;
  logic [7:0]            A_LO;
  logic [3:0]            DACK;
  logic                  MEMR_N;
  logic                  MEMW_N;
  logic [16+PAGE_W-1:0]  SYS_ADDR;
  logic                  ADDR_VALID;
  logic [1:0]            ACT_CH;
  logic [3:0]            BOUNDARY_ERR;

  modport master (
    output page_cs, page_wr, page_rd, page_sel, page_din,
    output AEN, ADSTB, DB_IN, A_LO, DACK, MEMR_N, MEMW_N,
    input  page_dout, SYS_ADDR, ADDR_VALID, ACT_CH, BOUNDARY_ERR
  );

  modport slave (
    input  page_cs, page_wr, page_rd, page_sel, page_din,
    input  AEN, ADSTB, DB_IN, A_LO, DACK, MEMR_N, MEMW_N,
    output page_dout, SYS_ADDR, ADDR_VALID, ACT_CH, BOUNDARY_ERR
  );
endinterface

// File: rtl/dma_addr_page_latch.sv
// rtl/dma_addr_page_latch.sv - 8237A upper-address latch and page register merge
//
// Purpose: captures A15..A8 from the controller data bus on ADSTB, merges it
// with the page register of the granted channel and A7..A0, and drives a
// registered system address plus address-valid strobe. Flags 64 KB wraps per
// channel, because the controller never carries into the page.
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous active-high reset
//   bus    dma_addr_page_latch_if.slave (CPU page port, controller bus, system address)
module dma_addr_page_latch #(
  parameter int PAGE_W = 8
) (
  input logic                   CLK,
  input logic                   RESET,
  dma_addr_page_latch_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  logic [1:0]        state;
  logic [PAGE_W-1:0] page [4];
  logic [7:0]        hi_latch;
  logic [7:0]        hi_next;
  logic              recapture;
  logic              wrap;
  logic [1:0]        dack_ch;
  logic [3:0]        err_next;
  logic              page_we;

  assign page_we = bus.page_cs & bus.page_wr;

  // Lowest-index acknowledge wins; no acknowledge decodes to channel 0.
  always_comb begin
    dack_ch = 2'd0;
    if (bus.DACK[0])      dack_ch = 2'd0;
    else if (bus.DACK[1]) dack_ch = 2'd1;
    else if (bus.DACK[2]) dack_ch = 2'd2;
    else if (bus.DACK[3]) dack_ch = 2'd3;
  end

  // ADSTB only counts while the controller owns the bus.
  assign recapture = (state == ST_XFER) & bus.AEN & bus.ADSTB;
  assign hi_next   = recapture ? bus.DB_IN : hi_latch;

  // A15..A8 jumping between 0xFF and 0x00 means the low 16 bits wrapped
  // without the page following.
  assign wrap = recapture &
                (((hi_latch == 8'hFF) && (bus.DB_IN == 8'h00)) ||
                 ((hi_latch == 8'h00) && (bus.DB_IN == 8'hFF)));

  // CPU write clears its channel's flag; a same-cycle wrap on that channel wins.
  always_comb begin
    err_next = bus.BOUNDARY_ERR;
    if (page_we) err_next[bus.page_sel] = 1'b0;
    if (wrap)    err_next[bus.ACT_CH]   = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      hi_latch   <= 8'h00;
      bus.ACT_CH <= 2'd0;
    end else if (!bus.AEN) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state      <= ST_GRANT;
          bus.ACT_CH <= dack_ch;
        end
        ST_GRANT: begin
          if (bus.ADSTB) begin
            state    <= ST_XFER;
            hi_latch <= bus.DB_IN;
          end
        end
        ST_XFER:  hi_latch <= hi_next;
        default:  state    <= ST_IDLE;
      endcase
    end
  end

  // The page read here is the pre-write value, so a CPU write shows up on
  // SYS_ADDR from the following XFER cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.SYS_ADDR   <= '0;
      bus.ADDR_VALID <= 1'b0;
    end else begin
      if (state == ST_XFER)
        bus.SYS_ADDR <= {page[bus.ACT_CH], hi_next, bus.A_LO};
      bus.ADDR_VALID <= (state == ST_XFER) & (~bus.MEMR_N | ~bus.MEMW_N);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) page[i] <= '0;
      bus.page_dout    <= '0;
      bus.BOUNDARY_ERR <= 4'b0000;
    end else begin
      if (page_we) page[bus.page_sel] <= bus.page_din;
      if (bus.page_cs & bus.page_rd) bus.page_dout <= page[bus.page_sel];
      bus.BOUNDARY_ERR <= err_next;
    end
  end

endmodule

// File: tb/tb_dma_addr_page_latch.sv
// tb/tb_dma_addr_page_latch.sv - self-checking bench for dma_addr_page_latch
module tb_dma_addr_page_latch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_addr_page_latch_if #(.PAGE_W(8)) bus ();

  dma_addr_page_latch #(.PAGE_W(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0]  op;     // 0 none, 1 write, 2 read
    logic [1:0]  sel;
    logic [7:0]  din;
    logic        aen;
    logic        adstb;
    logic [7:0]  db;
    logic [7:0]  alo;
    logic [3:0]  dack;
    logic        mr_n;
    logic        mw_n;
    logic [23:0] e_addr;
    logic        e_valid;
    logic [1:0]  e_act;
    logic [3:0]  e_err;
    logic [7:0]  e_dout;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: bus ownership and whether an upper byte has been
  // captured in this ownership period.
  logic [7:0]  m_pg [4];
  logic [7:0]  m_dout, m_hi;
  logic [23:0] m_addr;
  logic        m_valid;
  logic [1:0]  m_act;
  logic [3:0]  m_err;
  bit          m_owned, m_have;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] sel, input logic [7:0] din,
                       input logic aen, input logic adstb, input logic [7:0] db,
                       input logic [7:0] alo, input logic [3:0] dack,
                       input logic mr_n, input logic mw_n);
    bus.page_cs  = (op != 2'd0);
    bus.page_wr  = (op == 2'd1);
    bus.page_rd  = (op == 2'd2);
    bus.page_sel = sel;
    bus.page_din = din;
    bus.AEN      = aen;
    bus.ADSTB    = adstb;
    bus.DB_IN    = db;
    bus.A_LO     = alo;
    bus.DACK     = dack;
    bus.MEMR_N   = mr_n;
    bus.MEMW_N   = mw_n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    drive(2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pg[i] = 8'h00;
    m_dout = 8'h00; m_hi = 8'h00; m_addr = 24'h0; m_valid = 1'b0;
    m_act = 2'd0; m_err = 4'h0; m_owned = 0; m_have = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [7:0] old_pg [4];
    bit xfer, cap;
    old_pg = m_pg;
    xfer = m_owned && m_have;
    cap  = m_owned && bus.AEN && bus.ADSTB;
    if (xfer) m_addr = {old_pg[m_act], (cap ? bus.DB_IN : m_hi), bus.A_LO};
    m_valid = xfer && (!bus.MEMR_N || !bus.MEMW_N);
    if (bus.page_cs && bus.page_rd) m_dout = old_pg[bus.page_sel];
    if (bus.page_cs && bus.page_wr) begin
      m_pg[bus.page_sel]  = bus.page_din;
      m_err[bus.page_sel] = 1'b0;
    end
    if (cap && m_have &&
        ((m_hi == 8'hFF && bus.DB_IN == 8'h00) || (m_hi == 8'h00 && bus.DB_IN == 8'hFF)))
      m_err[m_act] = 1'b1;
    if (!bus.AEN) begin
      m_owned = 0;
      m_have  = 0;
    end else if (!m_owned) begin
      m_owned = 1;
      m_act   = 2'd0;
      for (int i = 3; i >= 0; i--) if (bus.DACK[i]) m_act = 2'(i);
    end else if (bus.ADSTB) begin
      m_hi   = bus.DB_IN;
      m_have = 1;
    end
  endtask

  function automatic vec_t v(input logic [1:0] op, input logic [1:0] sel, input logic [7:0] din,
                             input logic aen, input logic st, input logic [7:0] db,
                             input logic [7:0] alo, input logic [3:0] dack,
                             input logic mr_n, input logic mw_n,
                             input logic [23:0] ea, input logic ev, input logic [1:0] ec,
                             input logic [3:0] ee, input logic [7:0] ed);
    vec_t r;
    r.op = op; r.sel = sel; r.din = din; r.aen = aen; r.adstb = st; r.db = db;
    r.alo = alo; r.dack = dack; r.mr_n = mr_n; r.mw_n = mw_n;
    r.e_addr = ea; r.e_valid = ev; r.e_act = ec; r.e_err = ee; r.e_dout = ed;
    return r;
  endfunction

  initial begin
    idle_inputs();
    model_reset();
    tick();
    rst = 1'b0;

    chk("reset_sys_addr", bus.SYS_ADDR, 24'h0);
    chk("reset_valid", bus.ADDR_VALID, 1'b0);
    chk("reset_act", bus.ACT_CH, 2'd0);
    chk("reset_err", bus.BOUNDARY_ERR, 4'h0);
    chk("reset_dout", bus.page_dout, 8'h00);

    //        op  sel din    aen st db     alo    dack  mr mw   addr       v  act err    dout
    vecs.push_back(v(2, 0, 8'h00, 0, 0, 8'h00, 8'h00, 4'h0, 1, 1, 24'h000000, 0, 0, 4'h0, 8'h00));
    vecs.push_back(v(2, 3, 8'h00, 0, 0, 8'h00, 8'h00, 4'h0, 1, 1, 24'h000000, 0, 0, 4'h0, 8'h00));
    vecs.push_back(v(1, 2, 8'h12, 0, 0, 8'h00, 8'h00, 4'h0, 1, 1, 24'h000000, 0, 0, 4'h0, 8'h00));
    vecs.push_back(v(1, 0, 8'h34, 0, 0, 8'h00, 8'h00, 4'h0, 1, 1, 24'h000000, 0, 0, 4'h0, 8'h00));
    vecs.push_back(v(2, 2, 8'h00, 0, 0, 8'h00, 8'h00, 4'h0, 1, 1, 24'h000000, 0, 0, 4'h0, 8'h12));
    vecs.push_back(v(1, 1, 8'h0A, 0, 0, 8'h00, 8'h00, 4'h0, 1, 1, 24'h000000, 0, 0, 4'h0, 8'h12));
    vecs.push_back(v(1, 3, 8'h77, 0, 0, 8'h00, 8'h00, 4'h0, 1, 1, 24'h000000, 0, 0, 4'h0, 8'h12));
    // basic transfer on channel 1
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 4'h2, 1, 1, 24'h000000, 0, 1, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'h5C, 8'h31, 4'h2, 1, 0, 24'h000000, 0, 1, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h31, 4'h2, 1, 0, 24'h0A5C31, 1, 1, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 8'h31, 4'h2, 1, 0, 24'h0A5C31, 1, 1, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 8'h31, 4'h2, 1, 0, 24'h0A5C31, 0, 1, 4'h0, 8'h12));
    // multiple acknowledges, then DACK changes mid-grant
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 4'hC, 1, 1, 24'h0A5C31, 0, 2, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 4'h1, 1, 1, 24'h0A5C31, 0, 2, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'hFF, 8'h00, 4'h1, 0, 1, 24'h0A5C31, 0, 2, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 4'h0, 1, 1, 24'h12FF00, 0, 2, 4'h0, 8'h12));
    // channel 3: increment wrap, clear by page write
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 4'h8, 1, 1, 24'h12FF00, 0, 3, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'hFF, 8'h40, 4'h8, 1, 1, 24'h12FF00, 0, 3, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'h00, 8'h41, 4'h8, 1, 0, 24'h770041, 1, 3, 4'h8, 8'h12));
    vecs.push_back(v(1, 3, 8'h78, 1, 0, 8'h00, 8'h42, 4'h8, 1, 0, 24'h770042, 1, 3, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h43, 4'h8, 1, 0, 24'h780043, 1, 3, 4'h0, 8'h12));
    // decrement wrap, then wrap and write together (set wins)
    vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'hFF, 8'h44, 4'h8, 1, 0, 24'h78FF44, 1, 3, 4'h8, 8'h12));
    vecs.push_back(v(1, 3, 8'h79, 1, 1, 8'h00, 8'h45, 4'h8, 1, 0, 24'h780045, 1, 3, 4'h8, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 8'h45, 4'h0, 1, 1, 24'h790045, 0, 3, 4'h8, 8'h12));
    vecs.push_back(v(1, 3, 8'h05, 0, 0, 8'h00, 8'h00, 4'h0, 1, 1, 24'h790045, 0, 3, 4'h0, 8'h12));
    // transfer ending at 0xFF, then GRANT capture of 0x00 must not flag
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 4'h4, 1, 1, 24'h790045, 0, 2, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'hFF, 8'h00, 4'h4, 1, 1, 24'h790045, 0, 2, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h01, 4'h4, 0, 1, 24'h12FF01, 1, 2, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 8'h01, 4'h0, 1, 1, 24'h12FF01, 0, 2, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 4'h0, 1, 1, 24'h12FF01, 0, 0, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 4'h0, 1, 1, 24'h12FF01, 0, 0, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h02, 4'h0, 1, 0, 24'h340002, 1, 0, 4'h0, 8'h12));
    // ADSTB while AEN low is ignored; GRANT waits for ADSTB
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 8'h02, 4'h0, 1, 1, 24'h340002, 0, 0, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 0, 1, 8'hAB, 8'h02, 4'h0, 1, 0, 24'h340002, 0, 0, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h02, 4'h0, 1, 1, 24'h340002, 0, 0, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h05, 4'h0, 1, 0, 24'h340002, 0, 0, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 1, 8'hCD, 8'h06, 4'h0, 1, 0, 24'h340002, 0, 0, 4'h0, 8'h12));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 8'h00, 8'h07, 4'h0, 1, 0, 24'h34CD07, 1, 0, 4'h0, 8'h12));

    foreach (vecs[k]) begin
      drive(vecs[k].op, vecs[k].sel, vecs[k].din, vecs[k].aen, vecs[k].adstb, vecs[k].db,
            vecs[k].alo, vecs[k].dack, vecs[k].mr_n, vecs[k].mw_n);
      tick();
      chk($sformatf("vec%0d_sys_addr", k), bus.SYS_ADDR, vecs[k].e_addr);
      chk($sformatf("vec%0d_valid", k), bus.ADDR_VALID, vecs[k].e_valid);
      chk($sformatf("vec%0d_act", k), bus.ACT_CH, vecs[k].e_act);
      chk($sformatf("vec%0d_err", k), bus.BOUNDARY_ERR, vecs[k].e_err);
      chk($sformatf("vec%0d_dout", k), bus.page_dout, vecs[k].e_dout);
    end

    // Randomized traffic against the reference model.
    do_reset();
    begin
      logic aen_r = 1'b0;
      logic [7:0] db_r;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 9) == 0) aen_r = ~aen_r;
        case ($urandom_range(0, 3))
          0: db_r = 8'h00;
          1: db_r = 8'hFF;
          default: db_r = 8'($urandom);
        endcase
        drive(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0,
              2'($urandom), 8'($urandom), aen_r, ($urandom_range(0, 2) == 0), db_r,
              8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        model_step();
        tick();
        chk("rnd_sys_addr", bus.SYS_ADDR, m_addr);
        chk("rnd_valid", bus.ADDR_VALID, m_valid);
        chk("rnd_act", bus.ACT_CH, m_act);
        chk("rnd_err", bus.BOUNDARY_ERR, m_err);
        chk("rnd_dout", bus.page_dout, m_dout);
      end
    end

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    drive(2'd1, 2'd1, 8'h44, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1);
    tick();
    drive(2'd2, 2'd1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 4'h2, 1'b1, 1'b1);
    tick();
    drive(2'd0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h6E, 8'h20, 4'h2, 1'b1, 1'b0);
    tick();
    drive(2'd0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h21, 4'h2, 1'b1, 1'b0);
    tick();
    drive(2'd0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h22, 4'h2, 1'b1, 1'b0);
    tick();
    chk("pre_rst_valid", bus.ADDR_VALID, 1'b1);
    chk("pre_rst_addr", bus.SYS_ADDR, 24'h440022);
    chk("pre_rst_err", bus.BOUNDARY_ERR, 4'h2);
    chk("pre_rst_dout", bus.page_dout, 8'h44);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", bus.ADDR_VALID, 1'b0);
    chk("async_addr", bus.SYS_ADDR, 24'h0);
    chk("async_act", bus.ACT_CH, 2'd0);
    chk("async_err", bus.BOUNDARY_ERR, 4'h0);
    chk("async_dout", bus.page_dout, 8'h00);
    tick();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      drive(2'd2, 2'(s), 8'h00, 1'b0, 1'b1, 8'h99, 8'h11, 4'h2, 1'b1, 1'b0);
      tick();
      chk($sformatf("post_rst_page%0d", s), bus.page_dout, 8'h00);
      chk($sformatf("post_rst_valid%0d", s), bus.ADDR_VALID, 1'b0);
    end
    chk("post_rst_addr", bus.SYS_ADDR, 24'h0);
    drive(2'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h11, 4'h0, 1'b1, 1'b0);
    tick();
    chk("post_rst_grant_valid", bus.ADDR_VALID, 1'b0);
    drive(2'd0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h99, 8'h11, 4'h0, 1'b1, 1'b0);
    tick();
    drive(2'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h11, 4'h0, 1'b1, 1'b0);
    tick();
    chk("post_rst_xfer_addr", bus.SYS_ADDR, 24'h009911);
    chk("post_rst_xfer_valid", bus.ADDR_VALID, 1'b1);
    chk("post_rst_xfer_act", bus.ACT_CH, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dma_addr_page_latch.md
# dma_addr_page_latch

Downstream bus-side stage of the 8237A DMA controller. Captures the upper address byte the controller multiplexes onto its data bus during ADSTB and merges it with the per-channel page register for the granted channel. Drives a registered, full-width system address and an address-valid strobe. Flags 64 KB boundary crossings, since the controller never carries into the page.

## Interface

Parameters:
- PAGE_W, 8: page register width; system address width is 16+PAGE_W.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- page_cs  in  1  CPU select for page register access.
- page_wr  in  1  CPU write strobe, qualified by page_cs.
- page_rd  in  1  CPU read strobe, qualified by page_cs.
- page_sel  in  2  channel whose page register is accessed.
- page_din  in  PAGE_W  CPU write data.
- page_dout  out  PAGE_W  registered read data.
- AEN  in  1  address enable from the controller (DMA owns bus).
- ADSTB  in  1  address strobe; DB_IN carries A15..A8 while high.
- DB_IN  in  8  controller data bus (upper address byte).
- A_LO  in  8  controller address lines A7..A0.
- DACK  in  4  active-high channel acknowledges.
- MEMR_N, MEMW_N  in  1  memory read/write strobes, active low.
- SYS_ADDR  out  16+PAGE_W  {page, A15..A8, A7..A0}.
- ADDR_VALID  out  1  system address valid for the current memory cycle.
- ACT_CH  out  2  encoded granted channel.
- BOUNDARY_ERR  out  4  sticky per-channel 64 KB wrap flags.

## Operation

Page registers:
- 4 x PAGE_W, reset 0.
- Write: page_cs & page_wr writes page_din to page[page_sel] at the clock edge.
- Read: page_cs & page_rd loads page_dout from page[page_sel] at the clock edge. Otherwise page_dout holds its value.
- A write to page[n] also clears BOUNDARY_ERR[n].
- A CPU write in the same cycle as a boundary detect on the same channel: the set wins.

Channel decode:
- ACT_CH is registered, lowest-index asserted DACK.
- Updated only in IDLE on AEN rise. Holds through the grant.
- No DACK asserted at AEN rise: ACT_CH = 0.

State machine (IDLE, GRANT, XFER):
- IDLE: AEN=1 -> GRANT.
- GRANT: ADSTB=1 -> XFER, capture hi_latch <= DB_IN.
- XFER: each cycle ADSTB=1 recaptures hi_latch; stays in XFER.
- Any state: AEN=0 -> IDLE.
- hi_latch resets to 0x00 and holds its value in IDLE.

Address generation:
- SYS_ADDR <= {page[ACT_CH], hi_latch_next, A_LO} every cycle in XFER. hi_latch_next is the value being captured this cycle if ADSTB=1.
- SYS_ADDR holds its value in IDLE/GRANT.
- ADDR_VALID <= (state==XFER) & (~MEMR_N | ~MEMW_N). Forced 0 in IDLE/GRANT.

Boundary detect:
- Applies to an ADSTB recapture in XFER.
- Set BOUNDARY_ERR[ACT_CH] on old hi_latch 0xFF -> new 0x00 (increment wrap) or 0x00 -> 0xFF (decrement wrap).
- The page value is never modified.
- The first capture in GRANT never flags.

Reset:
- Valid mid-transfer.
- Outputs: SYS_ADDR=0, ADDR_VALID=0, ACT_CH=0, BOUNDARY_ERR=0, page_dout=0.
- State IDLE, all page registers 0.

## Timing

- All outputs registered, 1-cycle latency from sampled inputs.
- SYS_ADDR reflects A_LO/ADSTB/DB_IN of cycle N at edge N+1.
- AEN falling at edge N: ADDR_VALID = 0 after edge N+1. SYS_ADDR keeps the last value.
- page_dout valid the cycle after the read strobe.
- A page write takes effect on SYS_ADDR at the next XFER cycle after the write edge. It may change mid-transfer.
- ADSTB sampled while AEN=0 is ignored.

## Test plan

- Page R/W: write 0x12 to ch2, 0x34 to ch0, read ch2 -> page_dout=0x12 next cycle; after reset every read returns 0x00.
- Basic transfer: page[1]=0x0A, DACK=0010, AEN=1, ADSTB with DB_IN=0x5C, A_LO=0x31, MEMW_N=0 -> ACT_CH=1, SYS_ADDR=0x0A5C31, ADDR_VALID=1.
- Multi-DACK: DACK=1100 at AEN rise -> ACT_CH=2; changing DACK mid-grant leaves ACT_CH=2.
- Increment wrap: ch3 in XFER, hi_latch 0xFF, ADSTB with DB_IN=0x00 -> BOUNDARY_ERR=1000, SYS_ADDR page bits unchanged; write page[3] -> BOUNDARY_ERR=0000. Repeat with 0x00 -> 0xFF to cover the decrement wrap.
- GRANT capture: first ADSTB with DB_IN=0x00 after a prior transfer ended at 0xFF -> BOUNDARY_ERR stays 0.
- Reset mid-XFER: assert RESET asynchronously while ADDR_VALID=1 -> ADDR_VALID, SYS_ADDR, ACT_CH, page_dout, BOUNDARY_ERR = 0 immediately; state IDLE; ADSTB ignored until a new AEN rise.
